// File: rtl/conv_pkg.sv
// Shared constants, FSM state encoding and bank-select codes for the CONV5x5 host memory.
package conv_pkg;
  localparam int DW        = 13;
  localparam int AW        = 12;
  localparam int IMG_WORDS = 4096;
  localparam int L0_WORDS  = 4096;
  localparam int L1_WORDS  = 1024;

  localparam int IMG_AW = $clog2(IMG_WORDS);
  localparam int L0_AW  = $clog2(L0_WORDS);
  localparam int L1_AW  = $clog2(L1_WORDS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ARM   = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam logic CSEL_L0 = 1'b0;
  localparam logic CSEL_L1 = 1'b1;

  // The layer-1 bank is shallower than the core's address space.
  function automatic logic l1_in_range(input logic [AW-1:0] addr);
    return addr < AW'(L1_WORDS);
  endfunction
endpackage

// File: rtl/conv_bank_ram.sv
// Single-write-port, asynchronous-read memory; contents are deliberately not reset.
module conv_bank_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 13,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read-before-write: a same-cycle write only becomes visible after the edge.
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/conv_host_mem.sv
// Host-side responder for CONV5x5: loads the image, arms the core, serves its
// image/result accesses while busy, then streams the layer-1 result out.
module conv_host_mem
  import conv_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic          csel,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          done,
  output logic          oob_err,
  output state_t        dbg_state_o
);
  // Handshakes (load in, result out): a word transfers on a rising edge where
  // valid & ready are both high; the producer holds data stable while valid & !ready.

  state_t             state_q, state_d;
  logic [IMG_AW-1:0]  ld_ptr_q, ld_ptr_d;
  logic [L1_AW-1:0]   dr_ptr_q, dr_ptr_d;
  logic               done_q, done_d;
  logic               oob_q, oob_d;

  logic               in_run, in_drain, ld_fire, out_fire;
  logic               wr_oob, rd_oob;
  logic               l0_we, l1_we;
  logic [L1_AW-1:0]   l1_raddr;
  logic [DW-1:0]      img_rdata, l0_rdata, l1_rdata;

  assign in_run   = (state_q == RUN);
  assign in_drain = (state_q == DRAIN);
  assign ld_ready = !reset && ((state_q == IDLE) || (state_q == LOAD));
  assign ld_fire  = ld_valid && ld_ready;
  assign out_fire = in_drain && out_ready;

  assign wr_oob = (csel == CSEL_L1) && !l1_in_range(caddr_wr);
  assign rd_oob = (csel == CSEL_L1) && !l1_in_range(caddr_rd);
  assign l0_we  = in_run && cwr && (csel == CSEL_L0);
  assign l1_we  = in_run && cwr && (csel == CSEL_L1) && !wr_oob;

  // The layer-1 read port is time-shared: core reads in RUN, the drain pointer in DRAIN.
  assign l1_raddr = in_drain ? dr_ptr_q : caddr_rd[L1_AW-1:0];

  conv_bank_ram #(.DEPTH(IMG_WORDS), .WIDTH(DW)) u_img (
    .clk     (clk),
    .we_i    (ld_fire),
    .waddr_i (ld_ptr_q),
    .wdata_i (ld_data),
    .raddr_i (iaddr[IMG_AW-1:0]),
    .rdata_o (img_rdata)
  );

  conv_bank_ram #(.DEPTH(L0_WORDS), .WIDTH(DW)) u_l0 (
    .clk     (clk),
    .we_i    (l0_we),
    .waddr_i (caddr_wr[L0_AW-1:0]),
    .wdata_i (cdata_wr),
    .raddr_i (caddr_rd[L0_AW-1:0]),
    .rdata_o (l0_rdata)
  );

  conv_bank_ram #(.DEPTH(L1_WORDS), .WIDTH(DW)) u_l1 (
    .clk     (clk),
    .we_i    (l1_we),
    .waddr_i (caddr_wr[L1_AW-1:0]),
    .wdata_i (cdata_wr),
    .raddr_i (l1_raddr),
    .rdata_o (l1_rdata)
  );

  always_comb begin
    cdata_rd = '0;
    if (in_run && crd) begin
      if (csel == CSEL_L0)  cdata_rd = l0_rdata;
      else if (!rd_oob)     cdata_rd = l1_rdata;
    end
  end

  assign idata       = in_run ? img_rdata : '0;
  assign ready       = (state_q == ARM);
  assign out_valid   = in_drain;
  assign out_data    = in_drain ? l1_rdata : '0;
  assign out_last    = in_drain && (dr_ptr_q == L1_AW'(L1_WORDS - 1));
  assign done        = done_q;
  assign oob_err     = oob_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d  = state_q;
    ld_ptr_d = ld_ptr_q;
    dr_ptr_d = dr_ptr_q;
    done_d   = 1'b0;
    oob_d    = oob_q || (in_run && ((cwr && wr_oob) || (crd && rd_oob)));
    case (state_q)
      IDLE: begin
        if (ld_fire) begin
          ld_ptr_d = ld_ptr_q + 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (ld_fire) begin
          ld_ptr_d = ld_ptr_q + 1'b1;
          if (ld_ptr_q == IMG_AW'(IMG_WORDS - 1)) state_d = ARM;
        end
      end
      ARM: begin
        if (busy) state_d = RUN;
      end
      RUN: begin
        if (!busy) begin
          state_d  = DRAIN;
          dr_ptr_d = '0;
        end
      end
      DRAIN: begin
        if (out_fire) begin
          dr_ptr_d = dr_ptr_q + 1'b1;
          if (out_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ld_ptr_q <= '0;
      dr_ptr_q <= '0;
      done_q   <= 1'b0;
      oob_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ld_ptr_q <= ld_ptr_d;
      dr_ptr_q <= dr_ptr_d;
      done_q   <= done_d;
      oob_q    <= oob_d;
    end
  end
endmodule
